wb_queue: RTL and testbench

//  Writeback queue feeding the single write port of the 32x32 register file.

---
 rtl/wb_queue_if.sv | 40 ++++
 rtl/wb_queue.sv | 161 ++++++++++++++++
 tb/tb_wb_queue.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// Bundle of producer, regfile write-port and forwarding signals around the writeback queue.
// The queue side uses the slave modport; producers/decode/regfile use master.
interface wb_queue_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        wb_hold;
    logic        reg_wren;
    logic [4:0]  w_reg0;
    logic [31:0] w_data;
    logic [4:0]  r_reg0;
    logic [4:0]  r_reg1;
    logic        fwd0_hit;
    logic [31:0] fwd0_data;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;

    modport slave (
        input  ld_valid, ld_reg, ld_data,
        input  alu_valid, alu_reg, alu_data,
        input  wb_hold, r_reg0, r_reg1,
        output ld_ready, alu_ready,
        output reg_wren, w_reg0, w_data,
        output fwd0_hit, fwd0_data, fwd1_hit, fwd1_data
    );

    modport master (
        output ld_valid, ld_reg, ld_data,
        output alu_valid, alu_reg, alu_data,
        output wb_hold, r_reg0, r_reg1,
        input  ld_ready, alu_ready,
        input  reg_wren, w_reg0, w_data,
        input  fwd0_hit, fwd0_data, fwd1_hit, fwd1_data
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: merges load and ALU results into one in-order regfile write stream
// and forwards the youngest pending value for each register read port.

module wb_queue_checker #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic        clk,
    input logic        reset_n,
    input logic [AW:0] count,
    input logic        reg_wren,
    input logic [4:0]  w_reg0,
    input logic [31:0] w_data,
    input logic        ld_ready,
    input logic        alu_ready
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        count <= DEPTH_C);
    a_idle_port_zero: assert property (@(posedge clk) disable iff (!reset_n)
        !reg_wren |-> (w_reg0 == 5'd0 && w_data == 32'd0));
    a_full_not_ready: assert property (@(posedge clk) disable iff (!reset_n)
        (count == DEPTH_C) |-> (!ld_ready && !alu_ready));
    a_write_needs_entry: assert property (@(posedge clk) disable iff (!reset_n)
        reg_wren |-> (count != (AW+1)'(0)));
endmodule

module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic       clk,
    input logic       reset_n,
    wb_queue_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } fwd_t;

    logic [4:0]       reg_mem_r  [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;

    logic [AW:0]      free_s;
    logic             ld_ready_s;
    logic             alu_ready_s;
    logic             ld_push_s;
    logic             alu_push_s;
    logic             pop_s;
    logic [AW-1:0]    alu_slot_s;
    logic [4:0]       w_reg_s;
    logic [31:0]      w_data_s;
    fwd_t             fwd0_s;
    fwd_t             fwd1_s;

    // Walk from head to tail so the youngest matching entry overwrites older ones.
    function automatic fwd_t fwd_lookup(input logic [4:0] sel);
        fwd_t          res;
        logic [AW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_r + AW'(i);
            if (sel != 5'd0 && valid_r[idx] && reg_mem_r[idx] == sel) begin
                res.hit  = 1'b1;
                res.data = data_mem_r[idx];
            end
        end
        return res;
    endfunction

    // Readiness uses registered count only; a same-cycle pop frees nothing until next cycle.
    always_comb begin
        free_s      = DEPTH_C - count_r;
        ld_ready_s  = (free_s >= ONE_C);
        alu_ready_s = (free_s >= TWO_C) || ((free_s >= ONE_C) && !bus.ld_valid);
        ld_push_s   = bus.ld_valid && ld_ready_s && (bus.ld_reg != 5'd0);
        alu_push_s  = bus.alu_valid && alu_ready_s && (bus.alu_reg != 5'd0);
        pop_s       = (count_r != (AW+1)'(0)) && !bus.wb_hold;
        alu_slot_s  = wr_ptr_r + AW'(ld_push_s);
    end

    // Write port shows the head entry only while a write is actually issued.
    always_comb begin
        w_reg_s  = 5'd0;
        w_data_s = 32'd0;
        if (pop_s) begin
            w_reg_s  = reg_mem_r[rd_ptr_r];
            w_data_s = data_mem_r[rd_ptr_r];
        end else begin
            w_reg_s  = 5'd0;
            w_data_s = 32'd0;
        end
    end

    // Forwarding lookups for both read ports.
    always_comb begin
        fwd0_s = fwd_lookup(bus.r_reg0);
        fwd1_s = fwd_lookup(bus.r_reg1);
    end

    assign bus.ld_ready  = ld_ready_s;
    assign bus.alu_ready = alu_ready_s;
    assign bus.reg_wren  = pop_s;
    assign bus.w_reg0    = w_reg_s;
    assign bus.w_data    = w_data_s;
    assign bus.fwd0_hit  = fwd0_s.hit;
    assign bus.fwd0_data = fwd0_s.data;
    assign bus.fwd1_hit  = fwd1_s.hit;
    assign bus.fwd1_data = fwd1_s.data;

    // Queue storage and pointers; load is written ahead of a same-cycle ALU result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_r[i]  <= 5'd0;
                data_mem_r[i] <= 32'd0;
            end
            valid_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + AW'(1);
            end
            if (ld_push_s) begin
                reg_mem_r[wr_ptr_r]  <= bus.ld_reg;
                data_mem_r[wr_ptr_r] <= bus.ld_data;
                valid_r[wr_ptr_r]    <= 1'b1;
            end
            if (alu_push_s) begin
                reg_mem_r[alu_slot_s]  <= bus.alu_reg;
                data_mem_r[alu_slot_s] <= bus.alu_data;
                valid_r[alu_slot_s]    <= 1'b1;
            end
            wr_ptr_r <= wr_ptr_r + AW'(ld_push_s) + AW'(alu_push_s);
            count_r  <= count_r + (AW+1)'(ld_push_s) + (AW+1)'(alu_push_s) - (AW+1)'(pop_s);
        end
    end

    wb_queue_checker #(.DEPTH(DEPTH), .AW(AW)) u_checker (
        .clk       (clk),
        .reset_n   (reset_n),
        .count     (count_r),
        .reg_wren  (pop_s),
        .w_reg0    (w_reg_s),
        .w_data    (w_data_s),
        .ld_ready  (ld_ready_s),
        .alu_ready (alu_ready_s)
    );
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic,
// with a write-order scoreboard checked by a monitor on every falling edge.
module tb_wb_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    ent_t exp_q[$];
    ent_t mon_e;

    wb_queue_if bus();

    wb_queue #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Write-port monitor: every issued write must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n) begin
            tests++;
            if (bus.reg_wren) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL wb_unexpected: got write r%0d=%h, expected no write", bus.w_reg0, bus.w_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.w_reg0 !== mon_e.r || bus.w_data !== mon_e.d) begin
                        fails++;
                        $display("FAIL wb_order: got r%0d=%h, expected r%0d=%h", bus.w_reg0, bus.w_data, mon_e.r, mon_e.d);
                    end
                end
            end else if (bus.w_reg0 !== 5'd0 || bus.w_data !== 32'd0) begin
                fails++;
                $display("FAIL wb_idle_zero: got r%0d=%h, expected 0/0", bus.w_reg0, bus.w_data);
            end
        end
    end

    task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad);
        bus.ld_valid  = lv;
        bus.ld_reg    = lr;
        bus.ld_data   = ld;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
    endtask

    task automatic push_exp(input logic [4:0] r, input logic [31:0] d);
        ent_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.wb_hold = 1'b0;
        bus.r_reg0  = 5'd5;
        bus.r_reg1  = 5'd7;
        reset_n     = 1'b0;
        #12;
        tests++;
        if ({bus.reg_wren, bus.w_reg0, bus.w_data} !== 38'd0) begin
            fails++;
            $display("FAIL reset_wport: got %b/%0d/%h, expected 0/0/0", bus.reg_wren, bus.w_reg0, bus.w_data);
        end
        tests++;
        if ({bus.fwd0_hit, bus.fwd0_data, bus.fwd1_hit, bus.fwd1_data} !== 66'd0) begin
            fails++;
            $display("FAIL reset_fwd: got %b %h %b %h, expected all 0", bus.fwd0_hit, bus.fwd0_data, bus.fwd1_hit, bus.fwd1_data);
        end
        tests++;
        if ({bus.ld_ready, bus.alu_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready: got %b%b, expected 11", bus.ld_ready, bus.alu_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_single();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_1234);
        push_exp(5'd8, 32'h0000_1234);
        @(negedge clk);
        tests++;
        if (bus.alu_ready !== 1'b1 || bus.reg_wren !== 1'b0) begin
            fails++;
            $display("FAIL single_pre: got ready=%b wren=%b, expected 1/0", bus.alu_ready, bus.reg_wren);
        end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        tests++;
        if (bus.reg_wren !== 1'b1 || bus.w_reg0 !== 5'd8 || bus.w_data !== 32'h0000_1234) begin
            fails++;
            $display("FAIL single_write: got %b r%0d=%h, expected 1 r8=00001234", bus.reg_wren, bus.w_reg0, bus.w_data);
        end
        @(negedge clk);
        tests++;
        if (bus.reg_wren !== 1'b0) begin
            fails++;
            $display("FAIL single_once: got wren=%b, expected 0", bus.reg_wren);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_both_same_cycle();
        bus.r_reg0 = 5'd5;
        drive(1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'hBBBB_0000);
        push_exp(5'd5, 32'hAAAA_0000);
        push_exp(5'd5, 32'hBBBB_0000);
        @(negedge clk);
        tests++;
        if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1 || bus.fwd0_hit !== 1'b0) begin
            fails++;
            $display("FAIL both_pre: got rdy=%b%b hit=%b, expected 11/0", bus.ld_ready, bus.alu_ready, bus.fwd0_hit);
        end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        tests++;
        if (bus.fwd0_hit !== 1'b1 || bus.fwd0_data !== 32'hBBBB_0000 || bus.w_data !== 32'hAAAA_0000) begin
            fails++;
            $display("FAIL both_fwd1: got hit=%b fwd=%h w=%h, expected 1/BBBB0000/AAAA0000", bus.fwd0_hit, bus.fwd0_data, bus.w_data);
        end
        @(negedge clk);
        tests++;
        if (bus.fwd0_hit !== 1'b1 || bus.fwd0_data !== 32'hBBBB_0000 || bus.w_data !== 32'hBBBB_0000) begin
            fails++;
            $display("FAIL both_fwd2: got hit=%b fwd=%h w=%h, expected 1/BBBB0000/BBBB0000", bus.fwd0_hit, bus.fwd0_data, bus.w_data);
        end
        @(negedge clk);
        tests++;
        if (bus.reg_wren !== 1'b0 || bus.fwd0_hit !== 1'b0 || bus.fwd0_data !== 32'd0) begin
            fails++;
            $display("FAIL both_done: got wren=%b hit=%b fwd=%h, expected 0/0/0", bus.reg_wren, bus.fwd0_hit, bus.fwd0_data);
        end
        @(posedge clk); #1;
        bus.r_reg0 = 5'd0;
    endtask

    task automatic test_hold_full();
        bus.wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h0000_0100 + 32'(i));
            push_exp(5'(i), 32'h0000_0100 + 32'(i));
            @(posedge clk); #1;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        @(negedge clk);
        tests++;
        if (bus.ld_ready !== 1'b0 || bus.alu_ready !== 1'b0 || bus.reg_wren !== 1'b0) begin
            fails++;
            $display("FAIL hold_full: got rdy=%b%b wren=%b, expected 00/0", bus.ld_ready, bus.alu_ready, bus.reg_wren);
        end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.wb_hold = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.reg_wren !== 1'b1 || bus.w_reg0 !== 5'd1 || bus.ld_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_first: got wren=%b r%0d ldrdy=%b, expected 1 r1 0", bus.reg_wren, bus.w_reg0, bus.ld_ready);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            tests++;
            if (bus.reg_wren !== 1'b1 || bus.w_reg0 !== 5'(k) || bus.ld_ready !== 1'b1) begin
                fails++;
                $display("FAIL hold_drain%0d: got wren=%b r%0d ldrdy=%b, expected 1 r%0d 1", k, bus.reg_wren, bus.w_reg0, bus.ld_ready, k);
            end
        end
        @(negedge clk);
        tests++;
        if (bus.reg_wren !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL hold_end: got wren=%b pending=%0d, expected 0/0", bus.reg_wren, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reg_zero();
        bus.r_reg1 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        tests++;
        if (bus.alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL r0_ready: got %b, expected 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (bus.reg_wren !== 1'b0 || bus.fwd1_hit !== 1'b0) begin
                fails++;
                $display("FAIL r0_nowrite: got wren=%b hit1=%b, expected 0/0", bus.reg_wren, bus.fwd1_hit);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.wb_hold = 1'b1;
        bus.r_reg0  = 5'd11;
        for (int i = 10; i <= 12; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h0000_0C00 + 32'(i));
            @(posedge clk); #1;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        tests++;
        if (bus.fwd0_hit !== 1'b1 || bus.fwd0_data !== 32'h0000_0C0B) begin
            fails++;
            $display("FAIL rst_prefwd: got %b %h, expected 1 00000C0B", bus.fwd0_hit, bus.fwd0_data);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (bus.fwd0_hit !== 1'b0 || bus.fwd0_data !== 32'd0 || bus.reg_wren !== 1'b0 || bus.ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_async: got hit=%b fwd=%h wren=%b ldrdy=%b, expected 0/0/0/1", bus.fwd0_hit, bus.fwd0_data, bus.reg_wren, bus.ld_ready);
        end
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        bus.wb_hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (bus.reg_wren !== 1'b0) begin
                fails++;
                $display("FAIL rst_nowrite: got wren=%b, expected 0", bus.reg_wren);
            end
        end
        // Filling four entries in two cycles only works if the whole queue was freed.
        @(posedge clk); #1;
        bus.wb_hold = 1'b1;
        drive(1'b1, 5'd13, 32'h0000_0D0D, 1'b1, 5'd14, 32'h0000_0E0E);
        push_exp(5'd13, 32'h0000_0D0D);
        push_exp(5'd14, 32'h0000_0E0E);
        @(negedge clk);
        tests++;
        if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_free_a: got %b%b, expected 11", bus.ld_ready, bus.alu_ready);
        end
        @(posedge clk); #1;
        drive(1'b1, 5'd15, 32'h0000_0F0F, 1'b1, 5'd16, 32'h0000_1010);
        push_exp(5'd15, 32'h0000_0F0F);
        push_exp(5'd16, 32'h0000_1010);
        @(negedge clk);
        tests++;
        if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_free_b: got %b%b, expected 11", bus.ld_ready, bus.alu_ready);
        end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        tests++;
        if (bus.ld_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_full: got ldrdy=%b, expected 0", bus.ld_ready);
        end
        @(posedge clk); #1;
        bus.wb_hold = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rst_drain: got %0d pending, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
        bus.r_reg0 = 5'd0;
    endtask

    task automatic test_free_one();
        bus.wb_hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h0000_0300 + 32'(i));
            push_exp(5'(i), 32'h0000_0300 + 32'(i));
            @(posedge clk); #1;
        end
        drive(1'b1, 5'd20, 32'h0000_0400, 1'b1, 5'd21, 32'h0000_0401);
        @(negedge clk);
        tests++;
        if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            fails++;
            $display("FAIL free1_split: got rdy=%b%b, expected 10", bus.ld_ready, bus.alu_ready);
        end
        push_exp(5'd20, 32'h0000_0400);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h0000_0401);
        bus.wb_hold = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.alu_ready !== 1'b0 || bus.reg_wren !== 1'b1) begin
            fails++;
            $display("FAIL free1_full: got alurdy=%b wren=%b, expected 0/1", bus.alu_ready, bus.reg_wren);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (bus.alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL free1_after_pop: got alurdy=%b, expected 1", bus.alu_ready);
        end
        push_exp(5'd21, 32'h0000_0401);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL free1_drain: got %0d pending, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        ent_t        mdl[$];
        ent_t        e;
        int          free;
        logic        exp_lr, exp_ar, exp_w, h0, h1;
        logic [31:0] d0, d1;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            bus.wb_hold = ($urandom_range(0, 3) == 0);
            bus.r_reg0  = 5'($urandom_range(0, 7));
            bus.r_reg1  = 5'($urandom_range(0, 7));
            @(negedge clk);
            free   = DEPTH - mdl.size();
            exp_lr = (free >= 1);
            exp_ar = (free >= 2) || (free >= 1 && !bus.ld_valid);
            exp_w  = (mdl.size() != 0) && !bus.wb_hold;
            h0 = 1'b0; d0 = 32'd0; h1 = 1'b0; d1 = 32'd0;
            foreach (mdl[i]) begin
                if (bus.r_reg0 != 5'd0 && mdl[i].r == bus.r_reg0) begin h0 = 1'b1; d0 = mdl[i].d; end
                if (bus.r_reg1 != 5'd0 && mdl[i].r == bus.r_reg1) begin h1 = 1'b1; d1 = mdl[i].d; end
            end
            tests++;
            if (bus.ld_ready !== exp_lr || bus.alu_ready !== exp_ar || bus.reg_wren !== exp_w) begin
                fails++;
                $display("FAIL rnd_ctrl c%0d: got rdy=%b%b wren=%b, expected %b%b/%b", c, bus.ld_ready, bus.alu_ready, bus.reg_wren, exp_lr, exp_ar, exp_w);
            end
            tests++;
            if (bus.fwd0_hit !== h0 || bus.fwd0_data !== d0 || bus.fwd1_hit !== h1 || bus.fwd1_data !== d1) begin
                fails++;
                $display("FAIL rnd_fwd c%0d: got %b %h %b %h, expected %b %h %b %h", c, bus.fwd0_hit, bus.fwd0_data, bus.fwd1_hit, bus.fwd1_data, h0, d0, h1, d1);
            end
            @(posedge clk); #1;
            if (exp_w) void'(mdl.pop_front());
            if (bus.ld_valid && exp_lr && bus.ld_reg != 5'd0) begin
                e.r = bus.ld_reg; e.d = bus.ld_data;
                mdl.push_back(e); exp_q.push_back(e);
            end
            if (bus.alu_valid && exp_ar && bus.alu_reg != 5'd0) begin
                e.r = bus.alu_reg; e.d = bus.alu_data;
                mdl.push_back(e); exp_q.push_back(e);
            end
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.wb_hold = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rnd_drain: got %0d pending, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_both_same_cycle();
        test_hold_full();
        test_reg_zero();
        test_reset_mid();
        test_free_one();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
